// File: rtl/reconf_sched.sv
// reconf_sched: queues host reconfiguration commands and applies them only between
// packets, bounding consecutive config commands so a waiting packet is not starved.
`ifndef DATA_BUS
`define DATA_BUS 16
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 16
`endif
`ifndef NEXT_TABLE_SIZE
`define NEXT_TABLE_SIZE 4
`endif

module reconf_sched #(
  parameter int FIFO_DEPTH    = 8,
  parameter int MAX_CFG_BURST = 4,
  parameter int NT_SIZE       = `NEXT_TABLE_SIZE
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid_i,
  output logic                                  cmd_ready_o,
  input  logic [2:0]                            cmd_op_i,
  input  logic [`DATA_BUS-1:0]                  cmd_a_i,
  input  logic [`DATA_BUS-1:0]                  cmd_b_i,
  input  logic [`DATA_BUS-1:0]                  cmd_c_i,
  input  logic [`DATA_BUS-1:0]                  cmd_d_i,
  input  logic                                  pkt_req_i,
  output logic                                  pkt_done_o,
  output logic                                  proc_start_o,
  input  logic                                  proc_ready_i,
  output logic                                  proc_mod_start_o,
  output logic [`ADDR_BUS-1:0]                  proc_mod_hit_action_addr_o,
  output logic [`ADDR_BUS-1:0]                  proc_mod_miss_action_addr_o,
  output logic                                  ps_mod_start_o,
  output logic [`DATA_BUS-1:0]                  ps_mod_hdr_id_o,
  output logic [`DATA_BUS-1:0]                  ps_mod_hdr_len_o,
  output logic [`DATA_BUS-1:0]                  ps_mod_next_tag_start_o,
  output logic [`DATA_BUS-1:0]                  ps_mod_next_tag_len_o,
  output logic [NT_SIZE-1:0][`DATA_BUS-1:0]     ps_mod_next_table_o,
  output logic                                  mt_mod_start_o,
  output logic [3:0]                            mt_mod_match_hdr_id_o,
  output logic [5:0]                            mt_mod_match_key_off_o,
  output logic [5:0]                            mt_mod_match_key_len_o,
  output logic                                  cfg_pending_o,
  output logic                                  err_o
);
  localparam int DW = `DATA_BUS;
  localparam int AW = `ADDR_BUS;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(MAX_CFG_BURST + 1);

  localparam logic [2:0] OP_PROC_MOD = 3'd0;
  localparam logic [2:0] OP_PS_MOD   = 3'd1;
  localparam logic [2:0] OP_MT_MOD   = 3'd2;
  localparam logic [2:0] OP_NT_WR    = 3'd3;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_CFG_HOLD, S_PKT_RUN, S_PKT_SETTLE} state_e;

  cmd_t                       fifo_q [FIFO_DEPTH];
  cmd_t                       cmd_in, head;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic [BW-1:0]              burst_cnt, burst_d;
  logic [NT_SIZE-1:0][DW-1:0] shadow;
  state_e                     state, state_d;
  logic                       push, pop, full, empty, burst_ok;
  logic                       proc_start_d, pkt_done_d, proc_mod_d, ps_mod_d, mt_mod_d;
  logic                       nt_we, err_set;

  assign cmd_in        = '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i, c: cmd_c_i, d: cmd_d_i};
  assign head          = fifo_q[rd_ptr];
  assign full          = (count == CW'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign cmd_ready_o   = !full;
  assign cfg_pending_o = !empty;
  assign push          = cmd_valid_i && !full;
  // Config wins in IDLE unless a packet has already waited out a full burst.
  assign burst_ok      = !pkt_req_i || (burst_cnt < BW'(MAX_CFG_BURST));
  assign pop           = (state == S_IDLE) && !empty && burst_ok;
  assign ps_mod_next_table_o = shadow;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:       if (pop) state_d = S_CFG_HOLD;
                    else if (pkt_req_i) state_d = S_PKT_RUN;
      S_CFG_HOLD:   state_d = S_IDLE;
      S_PKT_RUN:    if (proc_ready_i) state_d = S_PKT_SETTLE;
      S_PKT_SETTLE: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    proc_start_d = 1'b0;
    pkt_done_d   = 1'b0;
    proc_mod_d   = 1'b0;
    ps_mod_d     = 1'b0;
    mt_mod_d     = 1'b0;
    nt_we        = 1'b0;
    err_set      = 1'b0;
    burst_d      = burst_cnt;
    case (state)
      S_IDLE: begin
        if (pop) begin
          case (head.op)
            OP_PROC_MOD: proc_mod_d = 1'b1;
            OP_PS_MOD:   ps_mod_d   = 1'b1;
            OP_MT_MOD:   mt_mod_d   = 1'b1;
            OP_NT_WR:    nt_we      = (32'(head.a) < 32'(NT_SIZE));
            default:     err_set    = 1'b1;
          endcase
          if (!err_set && burst_cnt != {BW{1'b1}}) burst_d = burst_cnt + 1'b1;
        end else if (pkt_req_i) begin
          proc_start_d = 1'b1;
          burst_d      = '0;
        end
      end
      S_CFG_HOLD:   if (!pkt_req_i) burst_d = '0;
      S_PKT_RUN:    if (proc_ready_i) pkt_done_d = 1'b1;
                    else proc_start_d = 1'b1;
      S_PKT_SETTLE: if (!pkt_req_i) burst_d = '0;
      default: ;
    endcase
  end

  // Storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr                      <= '0;
      rd_ptr                      <= '0;
      count                       <= '0;
      burst_cnt                   <= '0;
      shadow                      <= '0;
      err_o                       <= 1'b0;
      proc_start_o                <= 1'b0;
      pkt_done_o                  <= 1'b0;
      proc_mod_start_o            <= 1'b0;
      ps_mod_start_o              <= 1'b0;
      mt_mod_start_o              <= 1'b0;
      proc_mod_hit_action_addr_o  <= '0;
      proc_mod_miss_action_addr_o <= '0;
      ps_mod_hdr_id_o             <= '0;
      ps_mod_hdr_len_o            <= '0;
      ps_mod_next_tag_start_o     <= '0;
      ps_mod_next_tag_len_o       <= '0;
      mt_mod_match_hdr_id_o       <= '0;
      mt_mod_match_key_off_o      <= '0;
      mt_mod_match_key_len_o      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      burst_cnt        <= burst_d;
      proc_start_o     <= proc_start_d;
      pkt_done_o       <= pkt_done_d;
      proc_mod_start_o <= proc_mod_d;
      ps_mod_start_o   <= ps_mod_d;
      mt_mod_start_o   <= mt_mod_d;
      if (err_set) err_o <= 1'b1;
      if (proc_mod_d) begin
        proc_mod_hit_action_addr_o  <= AW'(head.a);
        proc_mod_miss_action_addr_o <= AW'(head.b);
      end
      if (ps_mod_d) begin
        ps_mod_hdr_id_o         <= head.a;
        ps_mod_hdr_len_o        <= head.b;
        ps_mod_next_tag_start_o <= head.c;
        ps_mod_next_tag_len_o   <= head.d;
      end
      if (mt_mod_d) begin
        mt_mod_match_hdr_id_o  <= head.a[3:0];
        mt_mod_match_key_off_o <= head.b[5:0];
        mt_mod_match_key_len_o <= head.c[5:0];
      end
      for (int i = 0; i < NT_SIZE; i++)
        if (nt_we && 32'(head.a) == 32'(i)) shadow[i] <= head.b;
    end
  end
endmodule

// File: tb/tb_reconf_sched.sv
// Directed bench for reconf_sched: scoreboard of expected mod pulses plus
// packet timing, burst interleave, FIFO backpressure and error checks.
`timescale 1ns/1ps
`ifndef DATA_BUS
`define DATA_BUS 16
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 16
`endif
`ifndef NEXT_TABLE_SIZE
`define NEXT_TABLE_SIZE 4
`endif

module tb_reconf_sched;
  localparam int NT = `NEXT_TABLE_SIZE;
  localparam int DW = `DATA_BUS;
  localparam int AW = `ADDR_BUS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid_i = 1'b0;
  logic cmd_ready_o;
  logic [2:0] cmd_op_i = '0;
  logic [DW-1:0] cmd_a_i = '0, cmd_b_i = '0, cmd_c_i = '0, cmd_d_i = '0;
  logic pkt_req_i = 1'b0;
  logic pkt_done_o, proc_start_o;
  logic proc_ready_i;
  logic proc_mod_start_o, ps_mod_start_o, mt_mod_start_o;
  logic [AW-1:0] hit_o, miss_o;
  logic [DW-1:0] ps_id_o, ps_len_o, ps_ts_o, ps_tl_o;
  logic [NT-1:0][DW-1:0] nt_o;
  logic [3:0] mt_id_o;
  logic [5:0] mt_off_o, mt_len_o;
  logic cfg_pending_o, err_o;

  always #5 clk = ~clk;

  reconf_sched dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_c_i(cmd_c_i), .cmd_d_i(cmd_d_i),
    .pkt_req_i(pkt_req_i), .pkt_done_o(pkt_done_o),
    .proc_start_o(proc_start_o), .proc_ready_i(proc_ready_i),
    .proc_mod_start_o(proc_mod_start_o),
    .proc_mod_hit_action_addr_o(hit_o), .proc_mod_miss_action_addr_o(miss_o),
    .ps_mod_start_o(ps_mod_start_o),
    .ps_mod_hdr_id_o(ps_id_o), .ps_mod_hdr_len_o(ps_len_o),
    .ps_mod_next_tag_start_o(ps_ts_o), .ps_mod_next_tag_len_o(ps_tl_o),
    .ps_mod_next_table_o(nt_o),
    .mt_mod_start_o(mt_mod_start_o), .mt_mod_match_hdr_id_o(mt_id_o),
    .mt_mod_match_key_off_o(mt_off_o), .mt_mod_match_key_len_o(mt_len_o),
    .cfg_pending_o(cfg_pending_o), .err_o(err_o)
  );

  typedef struct {
    int                    kind;
    logic [63:0]           f0, f1, f2, f3;
    logic [NT-1:0][DW-1:0] nt;
  } exp_t;

  exp_t exp_q[$];
  logic [NT-1:0][DW-1:0] model_nt = '0;
  int tests = 0, fails = 0;
  int cyc = 0;
  int ready_lat = 10;
  int pcnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string got, input string exp);
    tests++;
    assert (got == exp) else begin
      fails++;
      $error("FAIL %s: observed %s expected %s", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Processor model: ready becomes a level ready_lat cycles after start rises.
  always @(posedge clk) begin
    if (rst || !proc_start_o) begin
      pcnt         <= 0;
      proc_ready_i <= 1'b0;
    end else begin
      pcnt         <= pcnt + 1;
      proc_ready_i <= (pcnt >= ready_lat - 1);
    end
  end

  // Monitor: packet timing, event log and scoreboard of mod pulses.
  int rise_cyc = 0, fall_cyc = -1, hi_len = 0, last_gap = -1, done_cnt = 0;
  string evt = "";
  int mt_cyc[$];
  logic [2:0] mods, prev_mods = '0;
  logic prev_ps = 1'b0, prev_done = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      prev_mods = '0; prev_ps = 1'b0; prev_done = 1'b0;
    end else begin
      mods = {mt_mod_start_o, ps_mod_start_o, proc_mod_start_o};
      if (proc_start_o && !prev_ps) begin
        if (fall_cyc >= 0) last_gap = cyc - fall_cyc;
        rise_cyc = cyc;
      end
      if (!proc_start_o && prev_ps) begin
        fall_cyc = cyc;
        hi_len   = cyc - rise_cyc;
      end
      if (pkt_done_o) begin
        done_cnt++;
        evt = {evt, "P"};
        chk("done_one_cycle", 64'(prev_done), 0);
      end
      if (mods != 3'b000) begin
        evt = {evt, "C"};
        chk("mod_onehot", 64'($onehot(mods)), 1);
        chk("mod_outside_pkt", 64'(proc_start_o | pkt_done_o), 0);
        chk("mod_one_cycle", 64'(prev_mods), 0);
        if (mt_mod_start_o) mt_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("sb_unexpected_pulse", 64'(mods), 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_kind", 64'(mods), 64'(3'b001 << e.kind));
          case (e.kind)
            0: begin
              chk("sb_proc_hit", 64'(hit_o), e.f0);
              chk("sb_proc_miss", 64'(miss_o), e.f1);
            end
            1: begin
              chk("sb_ps_hdr_id", 64'(ps_id_o), e.f0);
              chk("sb_ps_hdr_len", 64'(ps_len_o), e.f1);
              chk("sb_ps_tag_start", 64'(ps_ts_o), e.f2);
              chk("sb_ps_tag_len", 64'(ps_tl_o), e.f3);
              chk("sb_ps_next_table", 64'(nt_o), 64'(e.nt));
            end
            default: begin
              chk("sb_mt_hdr_id", 64'(mt_id_o), e.f0);
              chk("sb_mt_key_off", 64'(mt_off_o), e.f1);
              chk("sb_mt_key_len", 64'(mt_len_o), e.f2);
            end
          endcase
        end
      end
      prev_mods = mods; prev_ps = proc_start_o; prev_done = pkt_done_o;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [DW-1:0] a, b, c, d, output int waited);
    exp_t x;
    waited = 0;
    cmd_valid_i = 1'b1; cmd_op_i = op;
    cmd_a_i = a; cmd_b_i = b; cmd_c_i = c; cmd_d_i = d;
    while (!cmd_ready_o && waited < 300) begin tick(); waited++; end
    if (waited >= 300) begin
      chk("push_timeout_ready", 64'(cmd_ready_o), 1);
      cmd_valid_i = 1'b0;
      return;
    end
    x.kind = int'(op); x.nt = model_nt;
    x.f0 = 64'(a); x.f1 = 64'(b); x.f2 = 64'(c); x.f3 = 64'(d);
    if (op == 3'd2) begin
      x.f0 = 64'(a[3:0]); x.f1 = 64'(b[5:0]); x.f2 = 64'(c[5:0]);
    end
    if (op <= 3'd2) exp_q.push_back(x);
    if (op == 3'd3)
      for (int i = 0; i < NT; i++) if (32'(a) == 32'(i)) model_nt[i] = b;
    @(posedge clk);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!pkt_done_o && n < limit) begin tick(); n++; end
    if (!pkt_done_o) chk("pkt_done_timeout", 64'(pkt_done_o), 1);
  endtask

  task automatic wait_start(input int limit);
    int n = 0;
    while (!proc_start_o && n < limit) begin tick(); n++; end
    if (!proc_start_o) chk("proc_start_timeout", 64'(proc_start_o), 1);
  endtask

  function automatic int count_p(input string s);
    int n = 0;
    for (int i = 0; i < s.len(); i++) if (s[i] == 8'h50) n++;
    return n;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, d0;
    logic [NT-1:0][DW-1:0] nt_exp;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", 64'(cmd_ready_o), 1);
    chk("rst_cfg_pending", 64'(cfg_pending_o), 0);
    chk("rst_proc_start", 64'(proc_start_o), 0);
    chk("rst_pkt_done", 64'(pkt_done_o), 0);
    chk("rst_mod_starts", 64'({proc_mod_start_o, ps_mod_start_o, mt_mod_start_o}), 0);
    chk("rst_err", 64'(err_o), 0);
    chk("rst_hit", 64'(hit_o), 0);
    chk("rst_next_table", 64'(nt_o), 0);
    rst = 1'b0;
    tick();

    // PROC_MOD with no packet
    push(3'd0, 16'h0100, 16'h0200, 16'h0, 16'h0, w);
    chk("t2_pending", 64'(cfg_pending_o), 1);
    chk("t2_no_pulse_yet", 64'(proc_mod_start_o), 0);
    tick();
    chk("t2_pulse", 64'(proc_mod_start_o), 1);
    chk("t2_pending_fall", 64'(cfg_pending_o), 0);
    chk("t2_no_proc_start", 64'(proc_start_o), 0);
    tick();
    chk("t2_pulse_end", 64'(proc_mod_start_o), 0);
    chk("t2_hit_hold", 64'(hit_o), 64'h100);
    chk("t2_miss_hold", 64'(miss_o), 64'h200);
    chk("t2_proc_start_idle", 64'(proc_start_o), 0);

    // Packet with empty FIFO, followed immediately by a second packet
    ready_lat = 10;
    d0 = done_cnt;
    pkt_req_i = 1'b1;
    wait_done(100);
    chk("t3_start_len_ge10", 64'(hi_len >= 10), 1);
    chk("t3_one_done", 64'(done_cnt), 64'(d0 + 1));
    wait_start(50);
    chk("t3_restart_gap", 64'(last_gap), 2);
    wait_done(100);
    pkt_req_i = 1'b0;
    tick();
    chk("t3_two_dones", 64'(done_cnt), 64'(d0 + 2));
    chk("t3_start_low", 64'(proc_start_o), 0);

    // MT_MOD commands queued while a packet runs
    mt_cyc.delete();
    ready_lat = 20;
    pkt_req_i = 1'b1;
    wait_start(20);
    for (int i = 0; i < 3; i++) push(3'd2, 16'h00A2, 16'h004C, 16'h0046, 16'h0, w);
    chk("t4_no_mt_during_pkt", 64'(mt_cyc.size()), 0);
    wait_done(100);
    pkt_req_i = 1'b0;
    n = 0;
    while (mt_cyc.size() < 3 && n < 40) begin tick(); n++; end
    chk("t4_mt_count", 64'(mt_cyc.size()), 3);
    if (mt_cyc.size() == 3) begin
      chk("t4_after_settle", 64'(mt_cyc[0] - fall_cyc), 2);
      chk("t4_spacing_1", 64'(mt_cyc[1] - mt_cyc[0]), 2);
      chk("t4_spacing_2", 64'(mt_cyc[2] - mt_cyc[1]), 2);
    end

    // FIFO_DEPTH+2 commands while blocked by a packet; burst interleave
    repeat (3) tick();
    evt = "";
    ready_lat = 20;
    pkt_req_i = 1'b1;
    wait_start(20);
    for (int i = 0; i < 8; i++) push(3'd0, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h0, 16'h0, w);
    chk("t5_full_not_ready", 64'(cmd_ready_o), 0);
    chk("t5_full_pending", 64'(cfg_pending_o), 1);
    push(3'd0, 16'h1008, 16'h2008, 16'h0, 16'h0, w);
    chk("t5_push9_blocked", 64'(w > 0), 1);
    push(3'd0, 16'h1009, 16'h2009, 16'h0, 16'h0, w);
    n = 0;
    while (count_p(evt) < 4 && n < 3000) begin tick(); n++; end
    pkt_req_i = 1'b0;
    repeat (4) tick();
    chk_s("t5_event_order", evt, "PCCCCPCCCCPCCP");
    chk("t5_fifo_drained", 64'(cfg_pending_o), 0);

    // Next-table writes, PS_MOD, then an illegal op
    push(3'd3, 16'h0001, 16'h0800, 16'h0, 16'h0, w);
    push(3'd3, 16'(NT), 16'hBEEF, 16'h0, 16'h0, w);
    push(3'd1, 16'h0011, 16'h0022, 16'h0033, 16'h0044, w);
    chk("t6_err_before", 64'(err_o), 0);
    push(3'd5, 16'h0, 16'h0, 16'h0, 16'h0, w);
    repeat (10) tick();
    nt_exp = '0;
    nt_exp[1] = 16'h0800;
    chk("t6_next_table", 64'(nt_o), 64'(nt_exp));
    chk("t6_err_set", 64'(err_o), 1);
    repeat (5) tick();
    chk("t6_err_sticky", 64'(err_o), 1);

    // Reset mid-packet with commands queued
    ready_lat = 20;
    pkt_req_i = 1'b1;
    wait_start(20);
    push(3'd0, 16'h0AAA, 16'h0BBB, 16'h0, 16'h0, w);
    push(3'd1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, w);
    d0 = done_cnt;
    rst = 1'b1;
    pkt_req_i = 1'b0;
    exp_q.delete();
    model_nt = '0;
    @(posedge clk);
    tick();
    rst = 1'b0;
    chk("t7_start_cleared", 64'(proc_start_o), 0);
    chk("t7_fifo_flushed", 64'(cfg_pending_o), 0);
    chk("t7_err_cleared", 64'(err_o), 0);
    chk("t7_table_cleared", 64'(nt_o), 0);
    chk("t7_hit_cleared", 64'(hit_o), 0);
    repeat (30) tick();
    chk("t7_no_done", 64'(done_cnt), 64'(d0));
    chk("t7_no_pending", 64'(cfg_pending_o), 0);
    chk("sb_drained", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
